lcd_cmd_sched: RTL and testbench

LCD_CMD_SCHED -- requirements
Module: lcd_cmd_sched

---
 rtl/lcd_pkg.sv | 37 +++
 rtl/cmd_fifo.sv | 54 +++++
 rtl/lcd_cmd_sched.sv | 104 ++++++++++
 tb/tb_lcd_cmd_sched.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared opcode constants, state encoding and helpers for the LCD command scheduler.
package lcd_pkg;

  localparam int unsigned CMD_W = 4;
  localparam int unsigned CNT_W = 8;

  typedef logic [CMD_W-1:0] cmd_t;

  localparam cmd_t CMD_WRITE     = 4'd0;
  localparam cmd_t CMD_CLEAR     = 4'd1;
  localparam cmd_t CMD_HOME      = 4'd2;
  localparam cmd_t CMD_INVERT    = 4'd3;
  localparam cmd_t CMD_BRIGHT_UP = 4'd4;
  localparam cmd_t CMD_BRIGHT_DN = 4'd5;
  localparam cmd_t CMD_SCROLL_L  = 4'd6;
  localparam cmd_t CMD_SCROLL_R  = 4'd7;
  localparam cmd_t CMD_SCROLL_U  = 4'd8;
  localparam cmd_t CMD_SCROLL_D  = 4'd9;
  localparam cmd_t CMD_MIRROR_X  = 4'd10;
  localparam cmd_t CMD_MIRROR_Y  = 4'd11;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_HOLD     = 3'd3,
    ST_WAIT     = 3'd4,
    ST_FLUSH    = 3'd5,
    ST_FINISHED = 3'd6
  } state_e;

  // Opcodes above CMD_MIRROR_Y are reserved and never reach the controller.
  function automatic logic is_legal(cmd_t c);
    return c <= CMD_MIRROR_Y;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Registered synchronous command FIFO; power-of-two depth, head visible on dout.
module cmd_fifo
  import lcd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push,
  input  logic [CMD_W-1:0]                  din,
  input  logic                              pop,
  output logic [CMD_W-1:0]                  dout,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [CMD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_cmd_sched.sv
// Schedules host opcodes to the LCD controller: buffers, paces issues around
// controller busy, and terminates after the final write-back opcode.
module lcd_cmd_sched
  import lcd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  host_cmd,
  input  logic              host_valid,
  output logic              host_ready,
  output logic [CMD_W-1:0]  lcd_cmd,
  output logic              lcd_cmd_valid,
  input  logic              lcd_busy,
  input  logic              lcd_done,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic              err_illegal,
  output logic              sched_done
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  state_e           state;
  state_e           state_nxt;
  logic             xfer;
  logic             fifo_push;
  logic             fifo_pop;
  logic [CMD_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [CW-1:0]    count_nxt;
  logic             write_seen;
  logic             write_seen_nxt;
  logic             ready_nxt;

  assign xfer      = host_valid && host_ready;
  assign fifo_push = xfer && is_legal(host_cmd);
  assign fifo_pop  = (state == ST_ISSUE);

  cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (host_cmd),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next state plus the post-edge view used to register host_ready.
  always_comb begin
    state_nxt      = state;
    count_nxt      = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    write_seen_nxt = write_seen || (xfer && (host_cmd == CMD_WRITE));
    case (state)
      ST_INIT:     if (!lcd_busy) state_nxt = ST_IDLE;
      ST_IDLE:     if (!fifo_empty && !lcd_busy) state_nxt = ST_ISSUE;
      ST_ISSUE:    state_nxt = (lcd_cmd == CMD_WRITE) ? ST_FLUSH : ST_HOLD;
      ST_HOLD:     state_nxt = ST_WAIT;
      ST_WAIT:     if (!lcd_busy) state_nxt = ST_IDLE;
      ST_FLUSH:    if (lcd_done) state_nxt = ST_FINISHED;
      ST_FINISHED: state_nxt = ST_FINISHED;
      default:     state_nxt = ST_INIT;
    endcase
    ready_nxt = (count_nxt != CW'(FIFO_DEPTH)) && !write_seen_nxt &&
                (state_nxt != ST_FINISHED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_INIT;
      write_seen <= 1'b0;
    end else begin
      state      <= state_nxt;
      write_seen <= write_seen_nxt;
    end
  end

  // Registered outputs; lcd_cmd is captured from the head on entry to ISSUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_ready    <= 1'b0;
      lcd_cmd       <= '0;
      lcd_cmd_valid <= 1'b0;
      issued_cnt    <= '0;
      err_illegal   <= 1'b0;
      sched_done    <= 1'b0;
    end else begin
      host_ready    <= ready_nxt;
      lcd_cmd_valid <= (state_nxt == ST_ISSUE);
      sched_done    <= (state_nxt == ST_FINISHED);
      if (state_nxt == ST_ISSUE) lcd_cmd <= fifo_head;
      if (fifo_pop && (issued_cnt != {CNT_W{1'b1}})) issued_cnt <= issued_cnt + CNT_W'(1);
      if (xfer && !is_legal(host_cmd)) err_illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Self-checking bench for lcd_cmd_sched: per-cycle reference model plus directed scenarios.
module tb_lcd_cmd_sched;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] host_cmd = 4'd0;
  logic       host_valid = 1'b0;
  logic       host_ready;
  logic [3:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic       lcd_busy = 1'b0;
  logic       lcd_done = 1'b0;
  logic [7:0] issued_cnt;
  logic       err_illegal;
  logic       sched_done;

  always #5 clk = ~clk;

  lcd_cmd_sched #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .host_cmd      (host_cmd),
    .host_valid    (host_valid),
    .host_ready    (host_ready),
    .lcd_cmd       (lcd_cmd),
    .lcd_cmd_valid (lcd_cmd_valid),
    .lcd_busy      (lcd_busy),
    .lcd_done      (lcd_done),
    .issued_cnt    (issued_cnt),
    .err_illegal   (err_illegal),
    .sched_done    (sched_done)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: queue of pending opcodes plus the phase of the issue cycle.
  logic [3:0] mq[$];
  bit         m_boot, m_strobe, m_blind, m_wait, m_flush, m_done;
  bit         m_wseen, m_err, m_ready;
  int         m_cnt;
  logic [3:0] m_last;

  // Observed strobes for the directed literal checks.
  logic [3:0] seen[$];
  int         seen_cyc[$];
  bit         last_xfer;
  int         last_xfer_cyc;
  bit         auto_busy = 1'b0;
  bit         prev_strobe;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int seen_at(input int i);
    if (i < 0 || i >= seen.size()) return -1;
    return int'(seen[i]);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_boot = 0; m_strobe = 0; m_blind = 0; m_wait = 0; m_flush = 0; m_done = 0;
    m_wseen = 0; m_err = 0; m_ready = 0; m_cnt = 0; m_last = 4'd0;
  endtask

  task automatic model_edge();
    bit idle, xfer, n_strobe, was_write;
    bit n_blind, n_flush, n_done, n_wait;
    logic [3:0] n_last;
    idle      = m_boot && !m_strobe && !m_blind && !m_wait && !m_flush && !m_done;
    xfer      = host_valid && m_ready;
    n_strobe  = idle && (mq.size() > 0) && !lcd_busy;
    n_last    = n_strobe ? mq[0] : m_last;
    was_write = m_strobe && (m_last == 4'd0);
    n_blind   = m_strobe && !was_write;
    n_flush   = was_write || (m_flush && !lcd_done);
    n_done    = m_done || (m_flush && lcd_done);
    n_wait    = m_blind || (m_wait && lcd_busy);
    if (m_strobe) begin
      void'(mq.pop_front());
      if (m_cnt < 255) m_cnt++;
    end
    if (xfer) begin
      if (host_cmd >= 4'd12) m_err = 1;
      else begin
        mq.push_back(host_cmd);
        if (host_cmd == 4'd0) m_wseen = 1;
      end
    end
    m_boot   = m_boot || !lcd_busy;
    m_strobe = n_strobe;
    m_last   = n_last;
    m_blind  = n_blind;
    m_flush  = n_flush;
    m_done   = n_done;
    m_wait   = n_wait;
    m_ready  = (mq.size() < DEPTH) && !m_wseen && !m_done;
  endtask

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic step();
    @(negedge clk);
    if (reset) model_reset();
    check("host_ready",    int'(host_ready),    int'(m_ready));
    check("lcd_cmd_valid", int'(lcd_cmd_valid), int'(m_strobe));
    check("lcd_cmd",       int'(lcd_cmd),       int'(m_last));
    check("issued_cnt",    int'(issued_cnt),    m_cnt);
    check("err_illegal",   int'(err_illegal),   int'(m_err));
    check("sched_done",    int'(sched_done),    int'(m_done));
    if (lcd_cmd_valid) begin
      seen.push_back(lcd_cmd);
      seen_cyc.push_back(cyc);
    end
    last_xfer = host_valid && host_ready && !reset;
    if (last_xfer) last_xfer_cyc = cyc;
    prev_strobe = lcd_cmd_valid;
    if (!reset) model_edge();
    @(posedge clk);
    #1;
    cyc++;
    if (auto_busy) lcd_busy = prev_strobe;
  endtask

  task automatic push(input logic [3:0] op, input string nm);
    host_cmd   = op;
    host_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (last_xfer) return;
    end
    check({nm, "_accept_timeout"}, 0, 1);
  endtask

  task automatic wait_strobes(input int n, input string nm);
    for (int i = 0; i < 400; i++) begin
      if (seen.size() >= n) return;
      step();
    end
    check({nm, "_strobe_timeout"}, seen.size(), n);
  endtask

  task automatic do_reset(input logic busy);
    reset      = 1'b1;
    host_valid = 1'b0;
    lcd_done   = 1'b0;
    auto_busy  = 1'b0;
    lcd_busy   = busy;
    step();
    step();
    reset = 1'b0;
    seen.delete();
    seen_cyc.delete();
  endtask

  initial begin
    int n;
    model_reset();

    // Long image load: queued opcode must wait for busy to fall.
    do_reset(1'b1);
    check("rst_host_ready", int'(host_ready), 0);
    check("rst_issued_cnt", int'(issued_cnt), 0);
    push(4'd5, "s1");
    host_valid = 1'b0;
    repeat (69) step();
    check("s1_no_early_strobe", seen.size(), 0);
    lcd_busy = 1'b0;
    repeat (10) step();
    check("s1_strobes", seen.size(), 1);
    check("s1_opcode", seen_at(0), 5);
    check("s1_issued_cnt", int'(issued_cnt), 1);

    // Back-to-back pushes with a one-cycle busy pulse after each strobe.
    do_reset(1'b0);
    auto_busy = 1'b1;
    push(4'd1, "s2"); push(4'd3, "s2"); push(4'd7, "s2"); push(4'd9, "s2");
    host_valid = 1'b0;
    wait_strobes(4, "s2");
    repeat (6) step();
    check("s2_op0", seen_at(0), 1);
    check("s2_op1", seen_at(1), 3);
    check("s2_op2", seen_at(2), 7);
    check("s2_op3", seen_at(3), 9);
    for (int i = 1; i < 4 && i < seen_cyc.size(); i++)
      check("s2_spacing_ge4", int'(seen_cyc[i] - seen_cyc[i-1] >= 4), 1);
    check("s2_issued_cnt", int'(issued_cnt), 4);
    auto_busy = 1'b0;

    // Fill the buffer while the controller is busy.
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) push(4'(i + 1), "s3");
    host_cmd = 4'd9;
    step();
    check("s3_full_ready", int'(host_ready), 0);
    check("s3_full_no_xfer", int'(last_xfer), 0);
    lcd_busy = 1'b0;
    push(4'd9, "s3");
    host_valid = 1'b0;
    check("s3_ninth_after_pop", last_xfer_cyc, (seen_cyc.size() > 0) ? seen_cyc[0] + 1 : -1);
    wait_strobes(9, "s3");
    for (int i = 0; i < 9; i++) check("s3_order", seen_at(i), i + 1);

    // Illegal opcode is swallowed and flagged.
    do_reset(1'b0);
    push(4'd13, "s4");
    push(4'd2, "s4");
    host_valid = 1'b0;
    repeat (20) step();
    check("s4_err_illegal", int'(err_illegal), 1);
    check("s4_strobes", seen.size(), 1);
    check("s4_opcode", seen_at(0), 2);

    // Write-back opcode closes the queue and ends the schedule.
    do_reset(1'b0);
    push(4'd4, "s5");
    push(4'd0, "s5");
    host_cmd = 4'd6;
    step();
    check("s5_ready_after_write", int'(host_ready), 0);
    wait_strobes(2, "s5");
    repeat (5) step();
    check("s5_op0", seen_at(0), 4);
    check("s5_op1", seen_at(1), 0);
    check("s5_not_done_yet", int'(sched_done), 0);
    lcd_done = 1'b1;
    step();
    lcd_done = 1'b0;
    check("s5_sched_done", int'(sched_done), 1);
    repeat (10) step();
    host_valid = 1'b0;
    check("s5_no_more_strobes", seen.size(), 2);

    // Reset while waiting on a busy controller with commands queued.
    do_reset(1'b0);
    push(4'd1, "s6"); push(4'd2, "s6"); push(4'd3, "s6"); push(4'd4, "s6");
    host_valid = 1'b0;
    wait_strobes(1, "s6");
    lcd_busy = 1'b1;
    repeat (4) step();
    check("s6_issued_before_rst", int'(issued_cnt), 1);
    reset = 1'b1;
    #1;
    check("s6_rst_ready", int'(host_ready), 0);
    check("s6_rst_valid", int'(lcd_cmd_valid), 0);
    check("s6_rst_cmd", int'(lcd_cmd), 0);
    check("s6_rst_cnt", int'(issued_cnt), 0);
    step();
    reset = 1'b0;
    lcd_busy = 1'b0;
    n = seen.size();
    repeat (20) step();
    check("s6_discarded", seen.size(), n);
    push(4'd6, "s6");
    host_valid = 1'b0;
    wait_strobes(n + 1, "s6");
    check("s6_new_opcode", seen_at(n), 6);

    // Random traffic against the model.
    for (int t = 0; t < 6; t++) begin
      do_reset(1'($urandom_range(0, 1)));
      for (int c = 0; c < 300; c++) begin
        int r;
        r = int'($urandom_range(0, 99));
        host_valid = 1'($urandom_range(0, 1));
        if (r < 2)       host_cmd = 4'd0;
        else if (r < 12) host_cmd = 4'($urandom_range(12, 15));
        else             host_cmd = 4'($urandom_range(1, 11));
        lcd_busy = ($urandom_range(0, 9) < 3);
        lcd_done = ($urandom_range(0, 7) == 0);
        step();
      end
    end

    // Saturation of the issue counter.
    do_reset(1'b0);
    host_valid = 1'b1;
    for (int c = 0; c < 1200; c++) begin
      host_cmd = 4'($urandom_range(1, 11));
      step();
    end
    host_valid = 1'b0;
    check("sat_issued_cnt", int'(issued_cnt), 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
